// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states
// and the fixed results used for divide-by-zero and signed overflow.
package muldiv_pkg;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFix
   } state_e;

   // Widest operand the constants below cover; users slice to WIDTH.
   localparam int unsigned MaxWidth = 64;

   // Divide by zero: quotient is all ones.
   localparam logic [MaxWidth-1:0] DivZeroQuo = '1;
   // Signed overflow (INT_MIN / -1): remainder is zero.
   localparam logic [MaxWidth-1:0] OvfRem = '0;

   // Signed overflow quotient is INT_MIN of the operand width.
   function automatic logic [MaxWidth-1:0] ovf_quo(input int unsigned width);
      logic [MaxWidth-1:0] q;
      q = '0;
      q[width-1] = 1'b1;
      return q;
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OpMult) || (op == OpDiv);
   endfunction

   function automatic logic is_engine_op(input logic [2:0] op);
      return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 engine: shift-add multiply or restoring divide, one step per
// step_i pulse. The accumulator holds {hi, lo} of the product, or
// {remainder, quotient} of the division, after WIDTH steps.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               div_mode_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               div_q, div_d;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // Load operands or advance one multiply/divide step.
   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      div_d  = div_q;
      sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, opnd_q};
      if (load_i) begin
         div_d = div_mode_i;
         if (div_mode_i) begin
            // Dividend in the low half, divisor held aside.
            acc_d  = {{WIDTH{1'b0}}, a_i};
            opnd_d = b_i;
         end else begin
            // Multiplier in the low half is consumed LSB first.
            acc_d  = {{WIDTH{1'b0}}, b_i};
            opnd_d = a_i;
         end
      end else if (step_i) begin
         if (div_q) begin
            if (!diff[WIDTH]) begin
               acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (acc_q[0]) begin
               acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
               acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
         end
      end
   end

   // Engine state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         div_q  <= div_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer: accepts requests from execute, drives the unsigned
// iterative core, applies sign correction and owns HI/LO.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             rd_hilo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d;
   logic              neg_res_q, neg_res_d;  // negate product / quotient
   logic              neg_rem_q, neg_rem_d;  // negate remainder
   logic              div_q, div_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;

   logic              core_load, core_step;
   logic [2*WIDTH-1:0] core_acc;

   logic              op_signed, a_neg, b_neg;
   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [WIDTH-1:0]  quo, rem, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]  int_min;

   assign int_min   = ovf_quo(WIDTH)[WIDTH-1:0];
   assign op_signed = is_signed_op(op);
   assign a_neg     = op_signed & a[WIDTH-1];
   assign b_neg     = op_signed & b[WIDTH-1];
   assign abs_a     = a_neg ? -a : a;
   assign abs_b     = b_neg ? -b : b;

   assign quo      = core_acc[WIDTH-1:0];
   assign rem      = core_acc[2*WIDTH-1:WIDTH];
   assign prod_fix = neg_res_q ? -core_acc : core_acc;
   assign quo_fix  = div0_q ? DivZeroQuo[WIDTH-1:0] :
                     ovf_q  ? int_min :
                     neg_res_q ? -quo : quo;
   assign rem_fix  = ovf_q ? OvfRem[WIDTH-1:0] : (neg_rem_q ? -rem : rem);

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (core_load),
      .step_i     (core_step),
      .div_mode_i (is_div_op(op)),
      .a_i        (abs_a),
      .b_i        (abs_b),
      .acc_o      (core_acc)
   );

   // Next-state, engine control and HI/LO update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div_d     = div_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A flush in the same cycle drops the request.
            if (start && !cancel) begin
               if (is_engine_op(op)) begin
                  core_load = 1'b1;
                  state_d   = StRun;
                  cnt_d     = '0;
                  div_d     = is_div_op(op);
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  div0_d    = is_div_op(op) && (b == '0);
                  ovf_d     = (op == OpDiv) && (a == int_min) && (b == '1);
               end else if (op == OpMthi) begin
                  hi_d = a;
               end else if (op == OpMtlo) begin
                  lo_d = a;
               end
            end
         end
         StRun: begin
            if (cancel) begin
               state_d = StIdle;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LastCnt) begin
                  state_d = StFix;
               end
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!cancel) begin
               done_d = 1'b1;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div_q     <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div_q     <= div_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy  = (state_q != StIdle);
   assign stall = busy & rd_hilo;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed/unsigned results, divide
// corner cases, MTHI/MTLO, stall, cancel and mid-operation reset.
module tb_muldiv_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        rd_hilo;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_seq #(
      .WIDTH (32)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .rd_hilo (rd_hilo),
      .busy    (busy),
      .stall   (stall),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; leaves start low at the first negedge after the start edge.
   task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd6;
   endtask

   // n counts negedges since the start edge; returns at the done negedge (bounded).
   task automatic wait_done(output int n, output int nbusy, output int nstall);
      n      = 1;
      nbusy  = 0;
      nstall = 0;
      for (int i = 0; i < 45; i++) begin
         if (done) break;
         if (busy) nbusy++;
         if (stall) nstall++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      op    = 3'd4;
      a     = 32'hFFFF_FFFF;
      rd_hilo = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd6;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      rd_hilo = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mult_latency();
      int n, nb, ns;
      start_op(3'd0, 32'd3, 32'd2);
      wait_done(n, nb, ns);
      n_checks++; if (n !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", n); end
      n_checks++; if (nb !== 33) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 33", nb); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mult3x2_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'h6) begin n_fail++; $display("FAIL mult3x2_lo got %h want 6", lo); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_busy got %b want 0", busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end
   endtask

   task automatic test_mult_signs();
      int n, nb, ns;
      start_op(3'd0, 32'd5, 32'h8000_0000);
      wait_done(n, nb, ns);
      n_checks++; if (hi !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mult_s_hi got %h want fffffffd", hi); end
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL mult_s_lo got %h want 80000000", lo); end
      @(negedge clk);
      start_op(3'd1, 32'd5, 32'h8000_0000);
      wait_done(n, nb, ns);
      n_checks++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi got %h want 2", hi); end
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL multu_lo got %h want 80000000", lo); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n, nb, ns;
      start_op(3'd0, 32'hFFFF_FFFB, 32'd2);
      wait_done(n, nb, ns);
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFF6) begin n_fail++; $display("FAIL mult_neg_lo got %h want fffffff6", lo); end
      // New start issued in the done cycle.
      start_op(3'd0, 32'd0, 32'h8000_0000);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", busy); end
      wait_done(n, nb, ns);
      n_checks++; if (n !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", n); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL b2b_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL b2b_lo got %h want 0", lo); end
      @(negedge clk);
   endtask

   task automatic test_div();
      int n, nb, ns;
      start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, nb, ns);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_q got %h want fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_r got %h want ffffffff", hi); end
      @(negedge clk);
      start_op(3'd2, 32'd7, 32'hFFFF_FFFE);
      wait_done(n, nb, ns);
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negb_q got %h want fffffffd", lo); end
      n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negb_r got %h want 1", hi); end
      @(negedge clk);
      start_op(3'd3, 32'd7, 32'd0);
      wait_done(n, nb, ns);
      n_checks++; if (n !== 34) begin n_fail++; $display("FAIL divu0_latency got %0d want 34", n); end
      n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_q got %h want ffffffff", lo); end
      n_checks++; if (hi !== 32'd7) begin n_fail++; $display("FAIL divu0_r got %h want 7", hi); end
      @(negedge clk);
      start_op(3'd2, 32'hFFFF_FFF9, 32'd0);
      wait_done(n, nb, ns);
      n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_q got %h want ffffffff", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div0_r got %h want fffffff9", hi); end
      @(negedge clk);
      start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, nb, ns);
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_q got %h want 80000000", lo); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_r got %h want 0", hi); end
      @(negedge clk);
   endtask

   // Expects hi=0, lo=80000000 left by the overflow divide.
   task automatic test_mthi_mtlo();
      start_op(3'd4, 32'h0000_1234, 32'h0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done got %b want 0", done); end
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_hi got %h want 1234", hi); end
      n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL mthi_lo got %h want 80000000", lo); end
      start_op(3'd5, 32'h0000_5678, 32'h0);
      n_checks++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo_lo got %h want 5678", lo); end
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_hi got %h want 1234", hi); end
      start_op(3'd6, 32'h5555_5555, 32'h1);
      start_op(3'd7, 32'h6666_6666, 32'h1);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nop_busy got %b want 0", busy); end
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL nop_hi got %h want 1234", hi); end
      n_checks++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL nop_lo got %h want 5678", lo); end
      // Flush alongside start in idle drops the request.
      cancel = 1'b1;
      start_op(3'd0, 32'd3, 32'd3);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start_busy got %b want 0", busy); end
      start_op(3'd4, 32'h9999_9999, 32'h0);
      cancel = 1'b0;
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL cancel_mthi_hi got %h want 1234", hi); end
   endtask

   task automatic test_stall();
      int n, nb, ns;
      rd_hilo = 1'b1;
      start_op(3'd0, 32'd3, 32'd2);
      wait_done(n, nb, ns);
      n_checks++; if (ns !== 33) begin n_fail++; $display("FAIL stall_cycles got %0d want 33", ns); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_done_cycle got %b want 0", stall); end
      rd_hilo = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int n, nb, ns;
      start_op(3'd0, 32'd2, 32'd3);
      repeat (4) @(negedge clk);
      start_op(3'd1, 32'd7, 32'd7);
      wait_done(n, nb, ns);
      n_checks++; if (n !== 29) begin n_fail++; $display("FAIL busy_start_latency got %0d want 29", n); end
      n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL busy_start_lo got %h want 6", lo); end
      @(negedge clk);
   endtask

   task automatic test_cancel();
      int n, nb, ns, ndone;
      start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n, nb, ns);
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi got %h want fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo got %h want 1", lo); end
      @(negedge clk);
      rd_hilo = 1'b1;
      start_op(3'd0, 32'd3, 32'd2);
      repeat (9) @(negedge clk);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_mid_run got %b want 1", stall); end
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", busy); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cancel_stall got %b want 0", stall); end
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL cancel_no_done got %0d want 0", ndone); end
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cancel_hi got %h want fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL cancel_lo got %h want 1", lo); end
      rd_hilo = 1'b0;
   endtask

   task automatic test_reset_mid();
      int ndone;
      start_op(3'd0, 32'd3, 32'd2);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 0", hi); end
      n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 0", lo); end
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", ndone); end
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = 3'd6;
      a       = '0;
      b       = '0;
      cancel  = 1'b0;
      rd_hilo = 1'b0;
      @(negedge clk);
      test_reset();
      test_mult_latency();
      test_mult_signs();
      test_back_to_back();
      test_div();
      test_mthi_mtlo();
      test_stall();
      test_start_while_busy();
      test_cancel();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the CPU's multiply/divide resource.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage.
- Runs a radix-2 iterative engine: shift-add for multiply, restoring subtract for divide.
- Owns the HI/LO registers and exposes busy/stall so MFHI/MFLO wait for a pending result.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears state and HI/LO
- start  in  1  request valid; accepted only when busy=0
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=NOP
- a  in  WIDTH  multiplicand/dividend; write data for MTHI/MTLO
- b  in  WIDTH  multiplier/divisor
- cancel  in  1  abort the in-flight op (pipeline flush)
- rd_hilo  in  1  execute stage wants HI or LO this cycle
- busy  out  1  engine running; start is ignored while high
- stall  out  1  busy & rd_hilo (combinational)
- done  out  1  one-cycle pulse when a mult/div result lands in HI/LO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: busy=0, done=0, hi=0, lo=0; state=IDLE. Reset beats start and cancel in the same cycle.
- States:
  - IDLE: on start with op 0-3, latch |a|, |b| and sign flags; go to RUN. Signed ops take the absolute value; unsigned ops pass operands through.
  - RUN: WIDTH iterations, one per clock, with an iteration counter.
  - FIX: apply sign correction, write {hi,lo}, go to IDLE.
- Latency: start sampled at edge E0; busy=1 after E0 through E32; HI/LO written at E(WIDTH+1); busy=0 and done=1 for exactly the cycle after that edge. Total 33 busy cycles at WIDTH=32.
- MTHI/MTLO: single cycle, no busy, no done. Write hi (or lo) = a at E0; the other register is unchanged.
- NOP op, or start while busy: ignored, no state change.
- Multiply: 2*WIDTH-bit product; {hi,lo} = product. Signed result is negated when the sign flags differ.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (signed or unsigned): lo = all ones, hi = a. Still the full latency.
  - Signed overflow (INT_MIN / -1): lo = 0x80000000, hi = 0.
- cancel: while busy, go to IDLE next edge with busy=0; HI/LO keep their pre-op values; no done. In IDLE, cancel has no effect. Cancel together with start in IDLE drops the start.
- Reset mid-operation: IDLE, HI/LO=0, no done.
- done and a new accepted start may coincide: a start in the done cycle is accepted. Back-to-back ops incur no dead cycle.
- stall is purely combinational. The engine never reads rd_hilo.

Decomposition:
- muldiv_pkg holds:
  - op encodings (OP_MULT … OP_MTLO)
  - state enum {IDLE, RUN, FIX}
  - divide-by-zero and overflow result constants
- Sub-module muldiv_iter_core holds the unsigned engine:
  - 2*WIDTH accumulator, WIDTH-bit operand register, mode bit
  - one step per enable pulse
- muldiv_seq keeps the FSM, counter, sign handling, HI/LO, cancel and reset.

Test Plan:
- MULT a=3, b=2 -> done 34 cycles after the start edge; hi=0x00000000, lo=0x00000006; busy high 33 cycles.
- MULT a=5, b=0x80000000 -> hi=0xFFFFFFFD, lo=0x80000000. MULTU with the same operands -> hi=0x00000002, lo=0x80000000.
- MULT a=-5, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFF6. Then MULT a=0, b=0x80000000 back-to-back, start in the done cycle -> hi=lo=0.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- MTHI a=0x1234 -> hi=0x1234 next cycle, lo unchanged, busy stays 0.
- MULT started with rd_hilo=1 -> stall high for all busy cycles. Cancel asserted at RUN cycle 10 -> busy=0 next cycle, HI/LO unchanged, no done. Repeat with reset at RUN cycle 10 -> hi=lo=0.
